// File: rtl/multu_seq_ctrl_pkg.sv
// Shared function codes and sequencer state encoding for the multiply
// sequencer and its HI/LO register file.
package alu_pkg;

  localparam logic [5:0] IDLE_CODE = 6'b000000;
  localparam logic [5:0] MULTU     = 6'b011001;
  localparam logic [5:0] OUT_CODE  = 6'b111111;
  localparam logic [5:0] MFHI      = 6'b010000;
  localparam logic [5:0] MFLO      = 6'b010010;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_CLR  = 3'd1,
    ST_RUN  = 3'd2,
    ST_OUT  = 3'd3,
    ST_CAP  = 3'd4
  } mulseq_state_t;

endpackage

// File: rtl/multu_seq_ctrl_hilo_reg.sv
// Architectural HI/LO registers: loaded from the multiplier product,
// cleared by reset, read combinationally through MFHI/MFLO.
module hilo_reg
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               i_load,
  input  logic [2*WIDTH-1:0] i_product,
  input  logic [5:0]         i_rd_sel,
  output logic [WIDTH-1:0]   o_rd_data
);

  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_hi <= '0;
      r_lo <= '0;
    end else if (i_load) begin
      r_hi <= i_product[2*WIDTH-1:WIDTH];
      r_lo <= i_product[WIDTH-1:0];
    end
  end

  always_comb begin
    o_rd_data = '0;
    case (i_rd_sel)
      MFHI:    o_rd_data = r_hi;
      MFLO:    o_rd_data = r_lo;
      default: o_rd_data = '0;
    endcase
  end

endmodule

// File: rtl/multu_seq_ctrl.sv
// Start/busy/done sequencer driving the shift-add unsigned multiplier
// through clear, WIDTH iterations, output load and HI/LO capture.
//
// state | meaning
// IDLE  | waiting for start; done may be high for one cycle here
// CLR   | multiplier accumulator cleared, counter zeroed
// RUN   | one MULTU iteration per cycle, counter 0..WIDTH-1
// OUT   | multiplier loads its output register
// CAP   | product captured into HI/LO on the exiting edge
module multu_seq_ctrl
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH-1:0]   op_a,
  input  logic [WIDTH-1:0]   op_b,
  output logic               busy,
  output logic               done,
  output logic               mul_reset,
  output logic [5:0]         mul_signal,
  output logic [CNT_W-1:0]   mul_counter,
  output logic [WIDTH-1:0]   mul_a,
  output logic [WIDTH-1:0]   mul_b,
  input  logic [2*WIDTH-1:0] mul_product,
  input  logic [5:0]         rd_sel,
  output logic [WIDTH-1:0]   rd_data
);

  localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(WIDTH - 1);

  mulseq_state_t    r_state;
  logic [CNT_W-1:0] r_counter;
  logic [WIDTH-1:0] r_mul_a;
  logic [WIDTH-1:0] r_mul_b;
  logic             r_done;
  logic             w_cap;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_counter <= '0;
      r_mul_a   <= '0;
      r_mul_b   <= '0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_mul_a <= op_a;
            r_mul_b <= op_b;
            r_state <= ST_CLR;
          end
        end
        ST_CLR: begin
          r_counter <= '0;
          r_state   <= ST_RUN;
        end
        ST_RUN: begin
          if (r_counter == LP_LAST) begin
            r_counter <= '0;
            r_state   <= ST_OUT;
          end else begin
            r_counter <= r_counter + CNT_W'(1);
          end
        end
        ST_OUT: r_state <= ST_CAP;
        ST_CAP: begin
          r_done  <= 1'b1;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    mul_signal = IDLE_CODE;
    case (r_state)
      ST_RUN:  mul_signal = MULTU;
      ST_OUT:  mul_signal = OUT_CODE;
      default: mul_signal = IDLE_CODE;
    endcase
  end

  // External reset also clears the multiplier so an abort leaves no stale sum.
  assign mul_reset   = reset | (r_state == ST_CLR);
  assign busy        = (r_state != ST_IDLE);
  assign done        = r_done;
  assign mul_counter = r_counter;
  assign mul_a       = r_mul_a;
  assign mul_b       = r_mul_b;
  assign w_cap       = (r_state == ST_CAP);

  hilo_reg #(
    .WIDTH(WIDTH)
  ) u_hilo (
    .clk       (clk),
    .reset     (reset),
    .i_load    (w_cap),
    .i_product (mul_product),
    .i_rd_sel  (rd_sel),
    .o_rd_data (rd_data)
  );

endmodule

// File: tb/tb_multu_seq_ctrl.sv
// Directed bench for multu_seq_ctrl with a behavioural shift-add multiplier.
module tb_multu_seq_ctrl;

  localparam logic [5:0] C_MULTU = 6'b011001;
  localparam logic [5:0] C_OUT   = 6'b111111;
  localparam logic [5:0] C_MFHI  = 6'b010000;
  localparam logic [5:0] C_MFLO  = 6'b010010;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] op_a, op_b;
  logic        busy, done, mul_reset;
  logic [5:0]  mul_signal;
  logic [5:0]  mul_counter;
  logic [31:0] mul_a, mul_b;
  logic [63:0] mul_product;
  logic [5:0]  rd_sel;
  logic [31:0] rd_data;

  logic [63:0] acc;
  logic        inject;
  logic [63:0] inj_val;

  int vec  = 0;
  int miss = 0;

  multu_seq_ctrl #(.WIDTH(32), .CNT_W(6)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .op_a        (op_a),
    .op_b        (op_b),
    .busy        (busy),
    .done        (done),
    .mul_reset   (mul_reset),
    .mul_signal  (mul_signal),
    .mul_counter (mul_counter),
    .mul_a       (mul_a),
    .mul_b       (mul_b),
    .mul_product (mul_product),
    .rd_sel      (rd_sel),
    .rd_data     (rd_data)
  );

  always #5 clk = ~clk;

  // Shift-add multiplier: adds mul_a<<i when bit i of mul_b is set.
  always @(posedge clk) begin
    if (mul_reset) acc <= 64'd0;
    else if (mul_signal == C_MULTU && mul_b[mul_counter[4:0]])
      acc <= acc + ({32'd0, mul_a} << mul_counter);
    if (mul_signal == C_OUT) mul_product <= inject ? inj_val : acc;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vec++;
    assert (obs === exp) else begin
      miss++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic read_reg(input logic [5:0] sel, output logic [31:0] d);
    rd_sel = sel;
    #1;
    d = rd_data;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (done !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
  endtask

  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b);
    int n;
    op_a = a;
    op_b = b;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(n);
    check({tag, "_latency"}, 64'(n), 64'd35);
  endtask

  initial begin
    logic [31:0] d;
    logic [31:0] last_lo;
    int bad, n, dones, gap;

    reset = 1'b1; start = 1'b0; op_a = '0; op_b = '0;
    rd_sel = C_MFLO; inject = 1'b0; inj_val = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_mul_reset", 64'(mul_reset), 64'd1);
    check("rst_signal", 64'(mul_signal), 64'd0);
    check("rst_mul_a", 64'(mul_a), 64'd0);
    read_reg(C_MFHI, d);
    check("rst_hi", 64'(d), 64'd0);
    reset = 1'b0;
    tick();

    // basic 3*5 with full state walk
    op_a = 32'd3; op_b = 32'd5; start = 1'b1;
    tick();
    start = 1'b0;
    op_a = 32'd0;
    check("clr_busy", 64'(busy), 64'd1);
    check("clr_mul_reset", 64'(mul_reset), 64'd1);
    check("clr_signal", 64'(mul_signal), 64'd0);
    tick();
    bad = 0;
    for (int i = 0; i < 32; i++) begin
      if (mul_signal !== C_MULTU || mul_counter !== 6'(i) || mul_reset !== 1'b0) bad++;
      tick();
    end
    check("run_sweep", 64'(bad), 64'd0);
    check("out_signal", 64'(mul_signal), 64'h3F);
    tick();
    check("cap_signal", 64'(mul_signal), 64'd0);
    check("cap_busy", 64'(busy), 64'd1);
    check("cap_done", 64'(done), 64'd0);
    tick();
    check("e35_done", 64'(done), 64'd1);
    check("e35_busy", 64'(busy), 64'd0);
    read_reg(C_MFLO, d);
    check("basic_lo", 64'(d), 64'h0000000F);
    read_reg(C_MFHI, d);
    check("basic_hi", 64'(d), 64'd0);
    tick();
    check("done_fall", 64'(done), 64'd0);

    // maximum operands
    run_op("max", 32'hFFFFFFFF, 32'hFFFFFFFF);
    read_reg(C_MFHI, d);
    check("max_hi", 64'(d), 64'hFFFFFFFE);
    read_reg(C_MFLO, d);
    check("max_lo", 64'(d), 64'h00000001);
    tick();
    run_op("msb", 32'h80000000, 32'd2);
    read_reg(C_MFHI, d);
    check("msb_hi", 64'(d), 64'd1);
    read_reg(C_MFLO, d);
    check("msb_lo", 64'(d), 64'd0);
    tick();

    // busy protection
    op_a = 32'd7; op_b = 32'd6; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (11) tick();
    check("bp_counter", 64'(mul_counter), 64'd10);
    op_a = 32'd9; op_b = 32'd9; start = 1'b1;
    tick();
    start = 1'b0;
    op_b = 32'h1234;
    check("bp_mul_a", 64'(mul_a), 64'd7);
    check("bp_mul_b", 64'(mul_b), 64'd6);
    read_reg(C_MFLO, d);
    check("bp_lo_prev", 64'(d), 64'd0);
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (done === 1'b1) dones++;
    end
    check("bp_dones", 64'(dones), 64'd1);
    check("bp_idle", 64'(busy), 64'd0);
    check("bp_mul_b_held", 64'(mul_b), 64'd6);
    read_reg(C_MFLO, d);
    check("bp_lo", 64'(d), 64'd42);
    read_reg(C_MFHI, d);
    check("bp_hi", 64'(d), 64'd0);

    // back-to-back
    run_op("b2b1", 32'd4, 32'd4);
    read_reg(C_MFLO, d);
    check("b2b_lo1", 64'(d), 64'd16);
    op_a = 32'd2; op_b = 32'd3; start = 1'b1;
    tick();
    start = 1'b0;
    gap = 1;
    check("b2b_accept", 64'(busy), 64'd1);
    last_lo = '0;
    while (done !== 1'b1 && gap < 100) begin
      read_reg(C_MFLO, last_lo);
      tick();
      gap++;
    end
    check("b2b_gap", 64'(gap), 64'd36);
    check("b2b_lo_in_cap", 64'(last_lo), 64'd16);
    read_reg(C_MFLO, d);
    check("b2b_lo2", 64'(d), 64'd6);
    tick();

    // reset mid-operation, after HI/LO = 1/2
    run_op("pre", 32'd2, 32'h80000001);
    read_reg(C_MFHI, d);
    check("pre_hi", 64'(d), 64'd1);
    read_reg(C_MFLO, d);
    check("pre_lo", 64'(d), 64'd2);
    tick();
    op_a = 32'd5; op_b = 32'd5; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (21) tick();
    check("ar_counter", 64'(mul_counter), 64'd20);
    #2;
    reset = 1'b1;
    #1;
    check("ar_busy", 64'(busy), 64'd0);
    check("ar_mul_reset", 64'(mul_reset), 64'd1);
    check("ar_signal", 64'(mul_signal), 64'd0);
    read_reg(C_MFHI, d);
    check("ar_hi", 64'(d), 64'd0);
    read_reg(C_MFLO, d);
    check("ar_lo", 64'(d), 64'd0);
    tick();
    reset = 1'b0;
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (done === 1'b1) dones++;
    end
    check("ar_no_done", 64'(dones), 64'd0);
    run_op("post", 32'd10, 32'd10);
    read_reg(C_MFLO, d);
    check("post_lo", 64'(d), 64'd100);
    tick();

    // read mux with an injected product
    inject = 1'b1;
    inj_val = 64'hDEADBEEF_12345678;
    run_op("inj", 32'd1, 32'd1);
    inject = 1'b0;
    read_reg(C_MFHI, d);
    check("mux_hi", 64'(d), 64'hDEADBEEF);
    read_reg(C_MFLO, d);
    check("mux_lo", 64'(d), 64'h12345678);
    read_reg(6'h20, d);
    check("mux_other", 64'(d), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule
